// File: rtl/uart_periph_if.sv
// Peripheral bus bundle for uart_periph.
// One-cycle WE/RE strobes; RDATA is registered by the slave.
interface uart_periph_if;
  logic [1:0] ADDR;
  logic [7:0] WDATA;
  logic       WE;
  logic       RE;
  logic [7:0] RDATA;

  modport master (
    output ADDR, WDATA, WE, RE,
    input  RDATA
  );

  modport slave (
    input  ADDR, WDATA, WE, RE,
    output RDATA
  );
endinterface

// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: TX holding reg + shifter, RX FIFO,
// sticky OE/FE flags and a registered level interrupt.
module uart_periph #(
  parameter int CLKS_PER_BIT = 868,
  parameter int RX_DEPTH     = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  uart_periph_if.slave  bus,
  input  logic          RXD,
  output logic          TXD,
  output logic          UART_INT
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_e;

  logic       wr_tx, wr_st, wr_ctl, rd_rx;
  logic       rx_ne, rx_full, tx_rdy, tx_idle;
  logic       pop, rx_push, push_ok, fe_set, oe_set;
  logic [7:0] status;

  logic [7:0]  rdata_q, rdata_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        oe_q, oe_d, fe_q, fe_d, int_q, int_d;
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic [7:0]  mem_q [RX_DEPTH];

  st_e         tx_q, tx_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [2:0]  tbit_q, tbit_d;
  logic [7:0]  tsh_q, tsh_d, thr_q, thr_d;
  logic        thr_full_q, thr_full_d, tx_load, txd_q, txd_d;

  st_e         rx_q, rx_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [2:0]  rbit_q, rbit_d;
  logic [7:0]  rsh_q, rsh_d;
  logic        s1_q, s2_q, prev_q;

  assign wr_tx  = bus.WE & (bus.ADDR == 2'd1);
  assign wr_st  = bus.WE & (bus.ADDR == 2'd2);
  assign wr_ctl = bus.WE & (bus.ADDR == 2'd3);
  assign rd_rx  = bus.RE & (bus.ADDR == 2'd0);

  assign rx_ne   = wp_q != rp_q;
  assign rx_full = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign tx_rdy  = ~thr_full_q;
  assign tx_idle = ~thr_full_q & (tx_q == IDLE);
  assign status  = {2'b00, fe_q, oe_q, tx_idle, tx_rdy,
                    rx_full, rx_ne};

  // A same-cycle pop frees the slot the push needs.
  assign pop     = rd_rx & rx_ne;
  assign push_ok = rx_push & (~rx_full | pop);
  assign oe_set  = rx_push & rx_full & ~pop;

  always_comb begin
    rdata_d = rdata_q;
    if (bus.RE) begin
      unique case (1'b1)
        bus.ADDR == 2'd0:
          rdata_d = rx_ne ? mem_q[rp_q[AW-1:0]] : 8'h00;
        bus.ADDR == 2'd1: rdata_d = 8'h00;
        bus.ADDR == 2'd2: rdata_d = status;
        bus.ADDR == 2'd3: rdata_d = {6'b0, ctrl_q};
        default:          rdata_d = 8'h00;
      endcase
    end
  end

  always_comb begin
    ctrl_d = wr_ctl ? bus.WDATA[1:0] : ctrl_q;
    oe_d   = oe_set | (oe_q & ~(wr_st & bus.WDATA[4]));
    fe_d   = fe_set | (fe_q & ~(wr_st & bus.WDATA[5]));
    int_d  = (ctrl_q[0] & rx_ne) | (ctrl_q[1] & tx_rdy);
    wp_d   = push_ok ? wp_q + 1'b1 : wp_q;
    rp_d   = pop ? rp_q + 1'b1 : rp_q;
    thr_d  = (wr_tx & ~thr_full_q) ? bus.WDATA : thr_q;
    thr_full_d = (thr_full_q & ~tx_load) | (wr_tx & ~thr_full_q);
  end

  always_comb begin
    tx_d    = tx_q;
    tcnt_d  = tcnt_q;
    tbit_d  = tbit_q;
    tsh_d   = tsh_q;
    tx_load = 1'b0;
    unique case (tx_q)
      IDLE: if (thr_full_q) begin
        tx_load = 1'b1;
        tsh_d   = thr_q;
        tcnt_d  = '0;
        tx_d    = START;
      end
      START: if (tcnt_q == BIT_END) begin
        tcnt_d = '0;
        tbit_d = 3'd0;
        tx_d   = DATA;
      end else tcnt_d = tcnt_q + 1'b1;
      DATA: if (tcnt_q == BIT_END) begin
        tcnt_d = '0;
        tsh_d  = {1'b0, tsh_q[7:1]};
        tbit_d = tbit_q + 3'd1;
        if (tbit_q == 3'd7) tx_d = STOP;
      end else tcnt_d = tcnt_q + 1'b1;
      STOP: if (tcnt_q == BIT_END) begin
        tcnt_d = '0;
        // Chain straight into the next frame when a byte waits.
        if (thr_full_q) begin
          tx_load = 1'b1;
          tsh_d   = thr_q;
          tx_d    = START;
        end else tx_d = IDLE;
      end else tcnt_d = tcnt_q + 1'b1;
      default: tx_d = IDLE;
    endcase
    txd_d = (tx_d == START) ? 1'b0 :
            (tx_d == DATA)  ? tsh_d[0] : 1'b1;
  end

  always_comb begin
    rx_d    = rx_q;
    rcnt_d  = rcnt_q;
    rbit_d  = rbit_q;
    rsh_d   = rsh_q;
    rx_push = 1'b0;
    fe_set  = 1'b0;
    unique case (rx_q)
      IDLE: if (prev_q & ~s2_q) begin
        rcnt_d = '0;
        rx_d   = START;
      end
      START: if (rcnt_q == HALF_END) begin
        rcnt_d = '0;
        rbit_d = 3'd0;
        rx_d   = s2_q ? IDLE : DATA;
      end else rcnt_d = rcnt_q + 1'b1;
      DATA: if (rcnt_q == BIT_END) begin
        rcnt_d = '0;
        rsh_d  = {s2_q, rsh_q[7:1]};
        rbit_d = rbit_q + 3'd1;
        if (rbit_q == 3'd7) rx_d = STOP;
      end else rcnt_d = rcnt_q + 1'b1;
      STOP: if (rcnt_q == BIT_END) begin
        rcnt_d  = '0;
        rx_d    = IDLE;
        rx_push = s2_q;
        fe_set  = ~s2_q;
      end else rcnt_d = rcnt_q + 1'b1;
      default: rx_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rdata_q <= '0;   ctrl_q <= '0;
      oe_q <= 1'b0;    fe_q <= 1'b0;
      int_q <= 1'b0;   wp_q <= '0;
      rp_q <= '0;      thr_q <= '0;
      thr_full_q <= 1'b0;
      tx_q <= IDLE;    tcnt_q <= '0;
      tbit_q <= '0;    tsh_q <= '0;
      txd_q <= 1'b1;
      rx_q <= IDLE;    rcnt_q <= '0;
      rbit_q <= '0;    rsh_q <= '0;
      s1_q <= 1'b1;    s2_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      rdata_q <= rdata_d; ctrl_q <= ctrl_d;
      oe_q <= oe_d;       fe_q <= fe_d;
      int_q <= int_d;     wp_q <= wp_d;
      rp_q <= rp_d;       thr_q <= thr_d;
      thr_full_q <= thr_full_d;
      tx_q <= tx_d;       tcnt_q <= tcnt_d;
      tbit_q <= tbit_d;   tsh_q <= tsh_d;
      txd_q <= txd_d;
      rx_q <= rx_d;       rcnt_q <= rcnt_d;
      rbit_q <= rbit_d;   rsh_q <= rsh_d;
      s1_q <= RXD;        s2_q <= s1_q;
      prev_q <= s2_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wp_q[AW-1:0]] <= rsh_q;
  end

  assign bus.RDATA = rdata_q;
  assign TXD       = txd_q;
  assign UART_INT  = int_q;

endmodule

// File: doc/uart_periph.md
# uart_periph

Memory-mapped 8N1 UART that serves as the interrupt source for the core's `UART_INT` input. It sits on the core's peripheral bus and provides the following:
- a transmit holding register feeding a serial shifter;
- a 4-deep receive FIFO fed by an oversampling-free mid-bit receiver;
- a level interrupt asserted when enabled RX/TX conditions hold.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per serial bit (100 MHz / 115200); must be ≥ 4.
- `RX_DEPTH`, 4: receive FIFO entries; power of two.

Ports:
- `CLK` input 1: single clock; all state changes on the rising edge.
- `RESET` input 1: asynchronous, active-low reset.
- `ADDR` input 2: register select. 0 = RXDATA, 1 = TXDATA, 2 = STATUS, 3 = CTRL.
- `WDATA` input 8: write data.
- `WE` input 1: write strobe, one cycle per access.
- `RE` input 1: read strobe, one cycle per access.
- `RDATA` output 8: registered read data.
- `RXD` input 1: serial input; asynchronous to `CLK`.
- `TXD` output 1: serial output; idles high.
- `UART_INT` output 1: level interrupt to the core.

## Operation
**Reset values (`RESET` low):**
- `TXD` = 1, `RDATA` = 0x00, `UART_INT` = 0.
- FIFO is empty, holding register is empty, and the shifter is idle.
- CTRL = 0, OE = 0, FE = 0.
- Both FSMs return to IDLE. A frame in progress is abandoned.

**Register map:**
- **RXDATA (read):** returns the FIFO head and pops it. A read while the FIFO is empty returns 0x00 with no pop. Writes are ignored.
- **TXDATA (write):** loads the holding register if it is empty. A write while it is full is dropped. Reads return 0x00.
- **STATUS (read):**
  - bit0 RX_NE (FIFO not empty)
  - bit1 RX_FULL
  - bit2 TX_RDY (holding register empty)
  - bit3 TX_IDLE (holding register empty and shifter idle)
  - bit4 OE
  - bit5 FE
  - bits 7:6 read 0.
  - Writing 1 to bit4 or bit5 clears that flag; other bits are ignored.
- **CTRL (read/write):** bit0 RXIE, bit1 TXIE. Other bits read 0.
- `WE` and `RE` asserted in the same cycle: both take effect.

**Interrupt:** `UART_INT` = (RXIE & RX_NE) | (TXIE & TX_RDY). It is registered and stays asserted until the condition clears.

**TX FSM:** states IDLE → START → DATA → STOP → IDLE.
- In IDLE with the holding register full: move the byte to the shifter, empty the holding register, and enter START.
- START drives 0 for `CLKS_PER_BIT` cycles.
- DATA sends 8 bits, LSB first, `CLKS_PER_BIT` cycles each.
- STOP drives 1 for `CLKS_PER_BIT` cycles.
- At the end of STOP, if the holding register is full, go directly to START with no idle gap. Otherwise go to IDLE.

**RX FSM:** states IDLE → START → DATA → STOP → IDLE.
- `RXD` passes through a 2-flop synchronizer.
- A synchronized high-to-low transition in IDLE enters START.
- START samples at `CLKS_PER_BIT/2` cycles. If the sample is 1, this is a false start: return to IDLE with no flag set.
- DATA samples each bit `CLKS_PER_BIT` cycles after the previous sample, LSB first.
- STOP samples one bit later:
  - Sample = 1: push the byte to the FIFO.
  - Sample = 0: discard the byte and set FE.
- After either outcome, return to IDLE. A new start edge is detected from the next cycle.
- Push when the FIFO is full: drop the byte and set OE. Exception: if an RXDATA read pops in the same cycle, the pop occurs first, the push is accepted, and OE is unchanged.

## Timing
- `RDATA` is valid in the cycle after the `RE` cycle. The FIFO pop is visible in STATUS in that same cycle.
- For a TXDATA write in cycle T with the TX FSM idle:
  - TX_RDY = 0 in T+1 and returns to 1 in T+2.
  - `TXD` falls at the start of T+2.
  - The frame lasts exactly 10·`CLKS_PER_BIT` cycles.
- Receive latency: RX_NE rises at most 3 cycles after the stop-bit sample. This covers 2 synchronizer cycles plus the push.
- Flags are sticky: OE and FE stay set until cleared by a software write-1. A set event coinciding with a clear write leaves the flag set.
- Wrap-around: FIFO pointers are log2(`RX_DEPTH`)+1 bits wide. Full = MSBs differ and LSBs equal.
- Bit counters are sized ceil(log2(`CLKS_PER_BIT`)) bits and never wrap mid-bit.

## Test plan
- **Reset and TX frame.** Assert reset mid-TX frame. Check `TXD` = 1, STATUS = 0x0C, `UART_INT` = 0. Then with `CLKS_PER_BIT` = 16, write 0xA5 to TXDATA. Check `TXD` shows, 16 cycles per bit: start 0, bits 1,0,1,0,0,1,0,1, stop 1. Total 160 cycles.
- **Back-to-back TX.** Write 0x55, wait for TX_RDY, write 0x0F. Check the two frames are contiguous (320 cycles, no idle gap). Check TX_IDLE = 1 after the second stop bit.
- **RX loopback and read.** Drive 0x3C on `RXD`. Check STATUS bit0 = 1, the RXDATA read returns 0x3C, then STATUS bit0 = 0. Check an empty-FIFO read returns 0x00.
- **Overrun.** Send 5 bytes (0x01–0x05) without reading. Check RX_FULL = 1 and OE = 1. Check reads return 0x01–0x04. Write 0x10 to STATUS and check OE = 0.
- **Framing and false start.** Send 0x77 with stop bit 0: check FE = 1 and the FIFO stays empty. Send an 8-cycle low glitch: check no flag is set and the FIFO stays empty.
- **Interrupt.** Write CTRL = 0x02 while idle and check `UART_INT` = 1. Write TXDATA and check `UART_INT` = 0 for one cycle. Set CTRL = 0x01 and receive 0x99: check `UART_INT` = 1 until the RXDATA read.
